// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM fader.
package pwm_pkg;

    localparam int NCH_DEF    = 3;
    localparam int NBPC_DEF   = 8;
    localparam int NBPRE_DEF  = 16;
    localparam int NBRATE_DEF = 8;
    localparam int PWM_MAX    = (2 ** NBPC_DEF) - 1;

    // Smallest select width able to address n channels (never below 1 bit).
    function automatic int clog2_ch(input int n);
        int w;
        w = 1;
        while ((2 ** w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pwm_fader_if.sv
// Duty-load handshake bundle between a controller and the PWM fader.
interface pwm_fader_if #(
    parameter int nbch   = 2,
    parameter int nbpc   = 8,
    parameter int nbrate = 8
);
    logic              load_valid;
    logic              load_ready;
    logic [nbch-1:0]   load_ch;
    logic [nbpc-1:0]   load_duty;
    logic [nbrate-1:0] load_rate;

    modport master (
        output load_valid, load_ch, load_duty, load_rate,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_ch, load_duty, load_rate,
        output load_ready
    );
endinterface

// File: rtl/pwm_fade_ch.sv
// One PWM channel: current/target duty, ramp divider, compare and busy flag.
module pwm_fade_ch
    import pwm_pkg::*;
#(
    parameter int nbpc   = NBPC_DEF,
    parameter int nbrate = NBRATE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              boundary,
    input  logic              ld,
    input  logic [nbpc-1:0]   count,
    input  logic [nbpc-1:0]   ld_duty,
    input  logic [nbrate-1:0] ld_rate,
    output logic              pwm,
    output logic              busy
);

    logic [nbpc-1:0]   cur;
    logic [nbpc-1:0]   tgt;
    logic [nbrate-1:0] rate;
    logic [nbrate-1:0] rcnt;

    // A load on the boundary cycle takes priority, so cur only moves on the following boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= '0;
            tgt  <= '0;
            rate <= '0;
            rcnt <= '0;
            pwm  <= 1'b0;
            busy <= 1'b0;
        end else begin
            pwm  <= en && (count < cur);
            busy <= (cur != tgt);
            if (ld) begin
                tgt  <= ld_duty;
                rate <= ld_rate;
                rcnt <= ld_rate;
            end else if (boundary) begin
                if (rate == '0) begin
                    cur <= tgt;
                end else if (cur != tgt) begin
                    if (rcnt > nbrate'(1)) begin
                        rcnt <= rcnt - nbrate'(1);
                    end else begin
                        cur  <= (cur < tgt) ? cur + nbpc'(1) : cur - nbpc'(1);
                        rcnt <= rate;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel PWM generator with shared prescaler/counter and per-channel fade engines.
module pwm_fader
    import pwm_pkg::*;
#(
    parameter int nch    = NCH_DEF,
    parameter int nbpc   = NBPC_DEF,
    parameter int nbpre  = NBPRE_DEF,
    parameter int nbrate = NBRATE_DEF,
    parameter int nbch   = clog2_ch(nch)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [nbpre-1:0] prescale,
    pwm_fader_if.slave       load,
    output logic [nch-1:0]   pwm_out,
    output logic [nch-1:0]   busy,
    output logic             period_start
);

    logic [nbpre-1:0] pcnt;
    logic [nbpc-1:0]  count;
    logic             tick;
    logic             boundary;

    assign tick         = en && !rst && (pcnt == prescale);
    assign boundary     = tick && (count == {nbpc{1'b1}});
    assign period_start = boundary;

    // Using >= lets a shrinking prescale pull pcnt back to 0 without a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt  <= '0;
            count <= '0;
        end else if (en) begin
            pcnt <= (pcnt >= prescale) ? '0 : pcnt + nbpre'(1);
            if (tick) begin
                count <= count + nbpc'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load.load_ready <= 1'b0;
        end else begin
            load.load_ready <= 1'b1;
        end
    end

    for (genvar i = 0; i < nch; i++) begin : g_ch
        logic ld;

        assign ld = load.load_valid && load.load_ready && (load.load_ch == nbch'(i));

        pwm_fade_ch #(
            .nbpc   (nbpc),
            .nbrate (nbrate)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .boundary (boundary),
            .ld       (ld),
            .count    (count),
            .ld_duty  (load.load_duty),
            .ld_rate  (load.load_rate),
            .pwm      (pwm_out[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader: cycle model plus hand-computed duty/spacing checks.
module tb_pwm_fader;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] prescale;
    logic [2:0]  pwm_out;
    logic [2:0]  busy;
    logic        period_start;

    int passed;
    int total;
    bit done;

    pwm_fader_if #(.nbch(2), .nbpc(4), .nbrate(8)) lif ();

    pwm_fader #(
        .nch    (3),
        .nbpc   (4),
        .nbpre  (16),
        .nbrate (8),
        .nbch   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .prescale     (prescale),
        .load         (lif),
        .pwm_out      (pwm_out),
        .busy         (busy),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tick/period arithmetic and one-LSB-per-rate-periods ramping.
    int  m_pcnt;
    int  m_count;
    int  m_cur[3];
    int  m_tgt[3];
    int  m_rate[3];
    int  m_rcnt[3];
    bit  m_ready;
    bit  [2:0] m_pwm;
    bit  [2:0] m_busy;
    bit  started;

    always @(posedge clk) begin : model
        bit tick;
        bit wrap;
        started = 1'b1;
        if (rst) begin
            m_pcnt  = 0;
            m_count = 0;
            m_ready = 1'b0;
            m_pwm   = '0;
            m_busy  = '0;
            for (int i = 0; i < 3; i++) begin
                m_cur[i]  = 0;
                m_tgt[i]  = 0;
                m_rate[i] = 0;
                m_rcnt[i] = 0;
            end
        end else begin
            tick = en && (m_pcnt == int'(prescale));
            wrap = tick && (m_count == 15);
            for (int i = 0; i < 3; i++) begin
                m_pwm[i]  = en && (m_count < m_cur[i]);
                m_busy[i] = (m_cur[i] != m_tgt[i]);
            end
            for (int i = 0; i < 3; i++) begin
                if (lif.load_valid && m_ready && (int'(lif.load_ch) == i)) begin
                    m_tgt[i]  = int'(lif.load_duty);
                    m_rate[i] = int'(lif.load_rate);
                    m_rcnt[i] = int'(lif.load_rate);
                end else if (wrap && (m_cur[i] != m_tgt[i])) begin
                    if (m_rate[i] == 0) begin
                        m_cur[i] = m_tgt[i];
                    end else if (m_rcnt[i] > 1) begin
                        m_rcnt[i] = m_rcnt[i] - 1;
                    end else begin
                        m_cur[i]  = (m_cur[i] < m_tgt[i]) ? m_cur[i] + 1 : m_cur[i] - 1;
                        m_rcnt[i] = m_rate[i];
                    end
                end
            end
            if (en) begin
                m_pcnt = (m_pcnt >= int'(prescale)) ? 0 : m_pcnt + 1;
                if (tick) begin
                    m_count = (m_count + 1) % 16;
                end
            end
            m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started && !done) begin
            checkOutput("pwm_out", 32'(pwm_out), 32'(m_pwm));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("period_start", 32'(period_start),
                        32'(en && !rst && (m_pcnt == int'(prescale)) && (m_count == 15)));
            checkOutput("load_ready", 32'(lif.load_ready), 32'(m_ready));
        end
    end

    task automatic applyStimulus(input int ch, input int duty, input int rate);
        @(posedge clk);
        #1;
        lif.load_valid = 1'b1;
        lif.load_ch    = 2'(ch);
        lif.load_duty  = 4'(duty);
        lif.load_rate  = 8'(rate);
        @(posedge clk);
        #1;
        lif.load_valid = 1'b0;
    endtask

    task automatic countToPS(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (period_start) break;
            if (n > 3000) begin
                checkOutput("period_start_timeout", 32'(0), 32'(1));
                break;
            end
        end
    endtask

    task automatic waitPS();
        int n;
        countToPS(n);
    endtask

    task automatic measureWindow(output int h0, output int h1, output int h2);
        h0 = 0;
        h1 = 0;
        h2 = 0;
        repeat (16) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
        end
    endtask

    initial begin
        int h0, h1, h2, n, ps_seen;
        int exp_up[6];
        int exp_dn[3];
        exp_up = '{0, 1, 1, 2, 2, 3};
        exp_dn = '{2, 1, 1};
        passed = 0;
        total  = 0;
        done   = 1'b0;
        rst = 1'b1;
        en = 1'b1;
        prescale = 16'd0;
        lif.load_valid = 1'b0;
        lif.load_ch = '0;
        lif.load_duty = '0;
        lif.load_rate = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 32'(lif.load_ready), 32'(0));
        checkOutput("reset_pwm", 32'(pwm_out), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(lif.load_ready), 32'(1));

        // ch0 jumps to duty 5
        waitPS();
        applyStimulus(0, 5, 0);
        @(posedge clk);
        #1 checkOutput("busy0_set", 32'(busy[0]), 32'(1));
        waitPS();
        @(negedge clk);
        measureWindow(h0, h1, h2);
        checkOutput("duty5_ch0", 32'(h0), 32'(5));
        checkOutput("busy0_clear", 32'(busy[0]), 32'(0));

        // ch1 extremes
        applyStimulus(1, 0, 0);
        waitPS();
        @(negedge clk);
        measureWindow(h0, h1, h2);
        checkOutput("duty0_ch1", 32'(h1), 32'(0));
        applyStimulus(1, 15, 0);
        waitPS();
        @(negedge clk);
        measureWindow(h0, h1, h2);
        checkOutput("duty15_ch1", 32'(h1), 32'(15));

        // ch2 ramps up 0->3 at rate 2, then down to 1 at rate 1
        applyStimulus(2, 3, 2);
        waitPS();
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            measureWindow(h0, h1, h2);
            checkOutput($sformatf("fade_up_%0d", k), 32'(h2), 32'(exp_up[k]));
        end
        checkOutput("busy2_done", 32'(busy[2]), 32'(0));
        applyStimulus(2, 1, 1);
        waitPS();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            measureWindow(h0, h1, h2);
            checkOutput($sformatf("fade_dn_%0d", k), 32'(h2), 32'(exp_dn[k]));
        end

        // load on the boundary cycle of a fading channel
        waitPS();
        applyStimulus(0, 10, 1);
        applyStimulus(1, 10, 1);
        waitPS();
        repeat (16) @(posedge clk);
        #1;
        lif.load_valid = 1'b1;
        lif.load_ch    = 2'd0;
        lif.load_duty  = 4'd12;
        lif.load_rate  = 8'd1;
        @(posedge clk);
        #1 lif.load_valid = 1'b0;
        waitPS();
        @(negedge clk);
        measureWindow(h0, h1, h2);
        checkOutput("coincide_ch0", 32'(h0), 32'(7));
        checkOutput("coincide_ch1", 32'(h1), 32'(12));

        // prescaler spacing
        prescale = 16'd3;
        waitPS();
        countToPS(n);
        checkOutput("ps_spacing_a", 32'(n), 32'(64));
        countToPS(n);
        checkOutput("ps_spacing_b", 32'(n), 32'(64));
        prescale = 16'd5;
        waitPS();
        repeat (5) @(posedge clk);
        #1 prescale = 16'd1;
        countToPS(n);
        checkOutput("prescale_shrink", 32'(n + 4), 32'(37));

        // global enable
        prescale = 16'd0;
        waitPS();
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("en0_pwm", 32'(pwm_out), 32'(0));
        applyStimulus(1, 4, 0);
        ps_seen = 0;
        repeat (20) begin
            @(negedge clk);
            ps_seen += int'(period_start);
        end
        checkOutput("en0_no_ps", 32'(ps_seen), 32'(0));
        checkOutput("en0_busy1", 32'(busy[1]), 32'(1));
        @(posedge clk);
        #1 en = 1'b1;
        countToPS(n);
        checkOutput("en1_resume", 32'(n), 32'(12));

        // out-of-range channel is discarded
        applyStimulus(3, 9, 0);
        waitPS();
        @(negedge clk);
        measureWindow(h0, h1, h2);
        checkOutput("bad_ch_ch0", 32'(h0), 32'(12));
        checkOutput("bad_ch_ch1", 32'(h1), 32'(4));
        checkOutput("bad_ch_ch2", 32'(h2), 32'(1));

        // reset mid-fade
        applyStimulus(2, 15, 3);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_pwm", 32'(pwm_out), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_ready", 32'(lif.load_ready), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        waitPS();
        @(negedge clk);
        measureWindow(h0, h1, h2);
        checkOutput("post_rst_duty", 32'(h0 + h1 + h2), 32'(0));

        done = 1'b1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
